// File: rtl/regbank_wr_16x16b_pkg.sv
// Shared constants and state encoding for the 16 x 16-bit register bank write side.
// The bank is fixed at 16 registers addressed by a 4-bit address/pointer.
package regbank_wr_16x16b_pkg;

  localparam int unsigned WIDTH = 16;  // bits per register
  localparam int unsigned NREG  = 16;  // register count (fixed)
  localparam int unsigned AW    = 4;   // address / pointer width

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_wr_16x16b_decoder_4_16.sv
// 4-to-16 one-hot decoder with enable; drives per-register write/clear enables.
// Ports:
//   addr    in  4   register index
//   en      in  1   decode enable; all outputs 0 when low
//   onehot  out 16  onehot[addr] = en
module decoder_4_16
  import regbank_wr_16x16b_pkg::*;
(
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regbank_wr_16x16b.sv
// Write side of the 16 x 16-bit register bank. Writes go to ADDR or to the
// auto-increment pointer WPTR; clr_req starts a one-register-per-cycle sweep
// that zeroes the whole bank over 16 cycles. All registers appear on REGS,
// slice i = register i, feeding input i of the read mux.
// Ports:
//   clk       in   1    rising-edge clock
//   rst       in   1    synchronous active-high reset
//   we        in   1    write request
//   ADDR      in   4    explicit write address (auto_inc=0)
//   DIN       in   16   write data
//   auto_inc  in   1    1: write at WPTR then WPTR++, 0: write at ADDR
//   clr_req   in   1    start bulk clear
//   busy      out  1    high while clearing
//   wr_ack    out  1    pulse the cycle after an accepted write
//   WPTR      out  4    auto-increment pointer
//   REGS      out  256  flat register bus
module regbank_wr_16x16b
  import regbank_wr_16x16b_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         ADDR,
  input  logic [WIDTH-1:0]      DIN,
  input  logic                  auto_inc,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  wr_ack,
  output logic [AW-1:0]         WPTR,
  output logic [NREG*WIDTH-1:0] REGS
);

  state_t           state;
  logic [AW-1:0]    cc;
  logic [WIDTH-1:0] regs [NREG];

  logic             wr_fire;
  logic             clr_active;
  logic [AW-1:0]    wr_addr;
  logic [NREG-1:0]  wr_en;
  logic [NREG-1:0]  clr_en;

  // clr_req wins over a concurrent write; nothing is written while clearing
  assign wr_fire    = (state == ST_IDLE) && !clr_req && we;
  assign clr_active = (state == ST_CLEAR);
  assign wr_addr    = auto_inc ? WPTR : ADDR;

  decoder_4_16 u_wr_dec (
    .addr   (wr_addr),
    .en     (wr_fire),
    .onehot (wr_en)
  );

  decoder_4_16 u_clr_dec (
    .addr   (cc),
    .en     (clr_active),
    .onehot (clr_en)
  );

  // Control FSM, sweep counter and write pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cc     <= '0;
      WPTR   <= '0;
      busy   <= 1'b0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_fire;
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            cc    <= '0;
            busy  <= 1'b1;
          end else if (we && auto_inc) begin
            WPTR <= WPTR + 1'b1;
          end
        end
        ST_CLEAR: begin
          cc <= cc + 1'b1;
          if (cc == AW'(NREG - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            WPTR  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Register array with per-register clear/write enables
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (clr_en[i]) begin
          regs[i] <= '0;
        end else if (wr_en[i]) begin
          regs[i] <= DIN;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NREG); g++) begin : g_flat
    assign REGS[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_regbank_wr_16x16b.sv
module tb_regbank_wr_16x16b;

  logic         clk = 1'b0;
  logic         rst;
  logic         we;
  logic [3:0]   ADDR;
  logic [15:0]  DIN;
  logic         auto_inc;
  logic         clr_req;
  logic         busy;
  logic         wr_ack;
  logic [3:0]   WPTR;
  logic [255:0] REGS;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  regbank_wr_16x16b dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .ADDR     (ADDR),
    .DIN      (DIN),
    .auto_inc (auto_inc),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_ack   (wr_ack),
    .WPTR     (WPTR),
    .REGS     (REGS)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents, pointer, ack and remaining sweep length
  logic [15:0] m_regs [16];
  int          m_wptr;
  bit          m_ack;
  int          sweep_left;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      m_wptr = 0; m_ack = 1'b0; sweep_left = 0;
    end else if (sweep_left > 0) begin
      m_regs[16 - sweep_left] = 16'h0;
      sweep_left = sweep_left - 1;
      if (sweep_left == 0) m_wptr = 0;
      m_ack = 1'b0;
    end else if (clr_req) begin
      sweep_left = 16;
      m_ack = 1'b0;
    end else if (we) begin
      if (auto_inc) begin
        m_regs[m_wptr] = DIN;
        m_wptr = (m_wptr + 1) % 16;
      end else begin
        m_regs[ADDR] = DIN;
      end
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [255:0] flat;
      for (int i = 0; i < 16; i++) flat[i*16 +: 16] = m_regs[i];
      check("busy",   256'(busy),   256'(sweep_left > 0));
      check("wr_ack", 256'(wr_ack), 256'(m_ack));
      check("WPTR",   256'(WPTR),   256'(m_wptr));
      check("REGS",   REGS,         flat);
    end
  end

  function automatic logic [15:0] slice(input logic [255:0] bus, input int k);
    return bus[k*16 +: 16];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [255:0] tmp;
    rst = 1'b1; we = 1'b0; ADDR = '0; DIN = '0; auto_inc = 1'b0; clr_req = 1'b0;

    // 1: two reset cycles, then release
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_regs",   REGS,           256'h0);
    check("rst_wptr",   256'(WPTR),     256'h0);
    check("rst_busy",   256'(busy),     256'h0);
    check("rst_wr_ack", 256'(wr_ack),   256'h0);

    // 2: explicit write to register 5
    we = 1'b1; ADDR = 4'd5; DIN = 16'hBEEF;
    @(negedge clk); we = 1'b0;
    check("t2_reg5",   256'(REGS[95:80]), 256'h0BEEF);
    check("t2_ack",    256'(wr_ack),      256'h1);
    tmp = REGS; tmp[95:80] = 16'h0;
    check("t2_others", tmp,               256'h0);
    check("t2_wptr",   256'(WPTR),        256'h0);
    @(negedge clk);
    check("t2_ack_drop", 256'(wr_ack), 256'h0);

    // back-to-back writes to the same address: last value wins
    we = 1'b1; ADDR = 4'd9; DIN = 16'h1111;
    @(negedge clk); DIN = 16'h2222;
    @(negedge clk); we = 1'b0;
    check("b2b_ack",  256'(wr_ack),      256'h1);
    check("b2b_reg9", 256'(slice(REGS, 9)), 256'h2222);

    // 3: 17 auto-increment writes wrap the pointer and overwrite register 0
    for (int k = 0; k < 17; k++) begin
      we = 1'b1; auto_inc = 1'b1; DIN = 16'h1000 + 16'(k);
      @(negedge clk);
    end
    we = 1'b0; auto_inc = 1'b0;
    check("t3_reg0", 256'(slice(REGS, 0)), 256'h1010);
    for (int k = 1; k < 16; k++)
      check($sformatf("t3_reg%0d", k), 256'(slice(REGS, k)), 256'(16'h1000 + 16'(k)));
    check("t3_wptr", 256'(WPTR), 256'h1);

    // 4: clr_req with a concurrent write; write dropped, 16-cycle sweep
    we = 1'b1; ADDR = 4'd3; DIN = 16'hFFFF; clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0; auto_inc = 1'b1;
    check("t4_no_ack", 256'(wr_ack),          256'h0);
    check("t4_reg3",   256'(slice(REGS, 3)),  256'h1003);
    check("t4_busy",   256'(busy),            256'h1);
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    we = 1'b0; auto_inc = 1'b0;
    check("t4_busy_cycles", 256'(n),      256'd16);
    check("t4_regs_zero",   REGS,         256'h0);
    check("t4_wptr",        256'(WPTR),   256'h0);
    check("t4_ack",         256'(wr_ack), 256'h0);

    // 5: reset in sweep cycle 7 aborts the clear
    for (int k = 0; k < 16; k++) begin
      we = 1'b1; ADDR = 4'(k); DIN = 16'h2000 + 16'(k);
      @(negedge clk);
    end
    we = 1'b0; clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    repeat (7) @(negedge clk);
    check("t5_reg6_swept",   256'(slice(REGS, 6)), 256'h0);
    check("t5_reg7_pending", 256'(slice(REGS, 7)), 256'h2007);
    check("t5_reg15_pending", 256'(slice(REGS, 15)), 256'h200F);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t5_busy", 256'(busy), 256'h0);
    check("t5_regs", REGS,       256'h0);
    check("t5_wptr", 256'(WPTR), 256'h0);

    // bank usable after the aborted sweep
    we = 1'b1; ADDR = 4'd2; DIN = 16'hABCD;
    @(negedge clk); we = 1'b0;
    check("t5_post_ack",  256'(wr_ack),          256'h1);
    check("t5_post_reg2", 256'(slice(REGS, 2)),  256'hABCD);
    @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
